serial_mag_comp: RTL and testbench

Bit-serial receiving counterpart of the parallel 4-bit magnitude comparator. It accepts two unsigned operands A and B streamed in one bit per cycle, MSB first, with a valid qualifier. After WIDTH accepted bits it reports equal/greater/less on E/G/L and pulses done. It sits behind serial links or shift-register sources where the parallel operands are not available. Its results match the parallel comparator for the same A and B.

---
 rtl/serial_cmp_pkg.sv | 23 ++
 rtl/serial_mag_comp_bit_cmp_cell.sv | 20 ++
 rtl/serial_mag_comp.sv | 107 ++++++++++
 tb/tb_serial_mag_comp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and the
// {E,G,L} result encoding.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  // Folds the decision flags into {E,G,L}; undecided after all bits means equal.
  function automatic logic [2:0] res_encode(input logic decided,
                                            input logic gt,
                                            input logic lt);
    return {~decided, gt, lt};
  endfunction

endpackage

// File: rtl/serial_mag_comp_bit_cmp_cell.sv
// One MSB-first comparison stage: the first differing bit-pair fixes the
// outcome and every later pair passes the earlier decision through.
module bit_cmp_cell
  import serial_cmp_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic decided_in,
  input  logic gt_in,
  input  logic lt_in,
  output logic decided_out,
  output logic gt_out,
  output logic lt_out
);

  assign decided_out = decided_in | (a ^ b);
  assign gt_out      = gt_in | (~decided_in & a & ~b);
  assign lt_out      = lt_in | (~decided_in & ~a & b);

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: WIDTH bit-pairs MSB first,
// then a one-cycle done pulse with a one-hot {E,G,L} held until the next start.
module serial_mag_comp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic E,
  output logic G,
  output logic L
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             decided_q;
  logic             gt_q;
  logic             lt_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       res_q;

  logic decided_d;
  logic gt_d;
  logic lt_d;

  bit_cmp_cell u_cell (
    .a           (a_bit),
    .b           (b_bit),
    .decided_in  (decided_q),
    .gt_in       (gt_q),
    .lt_in       (lt_q),
    .decided_out (decided_d),
    .gt_out      (gt_d),
    .lt_out      (lt_d)
  );

  // Control FSM, bit counter, decision flags and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= CNT_W'(0);
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= RES_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= ST_SHIFT;
            busy_q    <= 1'b1;
            count_q   <= CNT_W'(0);
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            res_q     <= RES_NONE;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // Stalls (bit_valid low) leave everything untouched.
          if (bit_valid) begin
            count_q   <= count_q + CNT_W'(1);
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            if (count_q == CNT_W'(WIDTH - 1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              res_q   <= res_encode(decided_d, gt_d, lt_d);
            end else begin
              state_q <= ST_SHIFT;
            end
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          res_q   <= RES_NONE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign {E, G, L} = res_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed and random checks of serial_mag_comp at WIDTH=4, 1 and 8 using a
// per-instance queue of expected {E,G,L} results.
module tb_serial_mag_comp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, bv, ab, bb, busy, done, e4, g4, l4;
  logic start1, bv1, ab1, bb1, busy1, done1, e1, g1, l1;
  logic start8, bv8, ab8, bb8, busy8, done8, e8, g8, l8;

  int total = 0;
  int bad = 0;
  logic [2:0] q4[$];
  logic [2:0] q1[$];
  logic [2:0] q8[$];
  logic [2:0] last4;

  serial_mag_comp #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bv), .a_bit(ab), .b_bit(bb),
    .busy(busy), .done(done), .E(e4), .G(g4), .L(l4));

  serial_mag_comp #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bit_valid(bv1), .a_bit(ab1), .b_bit(bb1),
    .busy(busy1), .done(done1), .E(e1), .G(g1), .L(l1));

  serial_mag_comp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bit_valid(bv8), .a_bit(ab8), .b_bit(bb8),
    .busy(busy8), .done(done8), .E(e8), .G(g8), .L(l8));

  function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
    if (a == b) return 3'b100;
    else if (a > b) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start4(input logic [3:0] a, input logic [3:0] b);
    q4.push_back(model(8'(a), 8'(b)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("egl_cleared_on_start", 32'({e4, g4, l4}), 32'd0);
    chk("no_done_on_start", 32'(done), 32'd0);
  endtask

  // Streams a/b into dut4; start_mid raises start during the second bit,
  // b2b returns in the done cycle so the caller can restart immediately.
  task automatic feed4(input logic [3:0] a, input logic [3:0] b, input int stall_pos,
                       input int stall_len, input bit start_mid, input bit b2b);
    int cyc = 0;
    int waited = 0;
    int exp_cyc = 4;
    logic [2:0] exp;
    if (stall_pos >= 0 && stall_pos < 4) exp_cyc = 4 + stall_len;
    for (int i = 0; i < 4; i++) begin
      if (i == stall_pos) begin
        for (int s = 0; s < stall_len; s++) begin
          bv = 1'b0;
          @(negedge clk);
          cyc++;
          chk("busy_in_stall", 32'(busy), 32'd1);
        end
      end
      bv = 1'b1;
      ab = a[3-i];
      bb = b[3-i];
      start = start_mid && (i == 1);
      @(negedge clk);
      cyc++;
    end
    bv = 1'b0;
    start = 1'b0;
    while (!done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("done_latency", 32'(cyc + waited), 32'(exp_cyc));
    chk("busy_low_in_done", 32'(busy), 32'd0);
    exp = q4.pop_front();
    chk("egl_result", 32'({e4, g4, l4}), 32'(exp));
    chk("egl_onehot", 32'($countones({e4, g4, l4})), 32'd1);
    last4 = exp;
    if (!b2b) begin
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("egl_hold", 32'({e4, g4, l4}), 32'(last4));
      chk("idle_not_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic run1(input logic a, input logic b);
    int waited = 0;
    q1.push_back(model(8'(a), 8'(b)));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    bv1 = 1'b1; ab1 = a; bb1 = b;
    @(negedge clk);
    bv1 = 1'b0;
    while (!done1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("w1_done_latency", 32'(waited), 32'd0);
    chk("w1_result", 32'({e1, g1, l1}), 32'(q1.pop_front()));
    chk("w1_onehot", 32'($countones({e1, g1, l1})), 32'd1);
    @(negedge clk);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int waited = 0;
    q8.push_back(model(a, b));
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bv8 = 1'b1; ab8 = a[7-i]; bb8 = b[7-i];
      @(negedge clk);
    end
    bv8 = 1'b0;
    while (!done8 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("w8_done_latency", 32'(waited), 32'd0);
    chk("w8_result", 32'({e8, g8, l8}), 32'(q8.pop_front()));
    chk("w8_onehot", 32'($countones({e8, g8, l8})), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; bv = 1'b0; ab = 1'b0; bb = 1'b0;
    start1 = 1'b0; bv1 = 1'b0; ab1 = 1'b0; bb1 = 1'b0;
    start8 = 1'b0; bv8 = 1'b0; ab8 = 1'b0; bb8 = 1'b0;
    last4 = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_egl", 32'({e4, g4, l4}), 32'd0);
    chk("rst_egl_w1", 32'({e1, g1, l1}), 32'd0);
    chk("rst_egl_w8", 32'({e8, g8, l8}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start4(4'b1101, 4'b1010);
    feed4(4'b1101, 4'b1010, -1, 0, 1'b0, 1'b0);
    start4(4'b1100, 4'b1110);
    feed4(4'b1100, 4'b1110, -1, 0, 1'b0, 1'b0);
    start4(4'b0001, 4'b0001);
    feed4(4'b0001, 4'b0001, 2, 2, 1'b0, 1'b0);

    // Abort a comparison part-way through with reset.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bv = 1'b1; ab = 1'b1; bb = 1'b0;
    @(negedge clk);
    ab = 1'b0; bb = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_egl", 32'({e4, g4, l4}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    start4(4'b0111, 4'b1000);
    feed4(4'b0111, 4'b1000, -1, 0, 1'b0, 1'b0);

    // bit_valid in IDLE must not start or disturb anything.
    bv = 1'b1; ab = 1'b1; bb = 1'b0;
    repeat (2) @(negedge clk);
    bv = 1'b0;
    chk("idle_bv_busy", 32'(busy), 32'd0);
    chk("idle_bv_done", 32'(done), 32'd0);
    chk("idle_bv_egl_hold", 32'({e4, g4, l4}), 32'(last4));

    start4(4'b1010, 4'b1011);
    feed4(4'b1010, 4'b1011, -1, 0, 1'b1, 1'b1);
    start4(4'b0110, 4'b0110);
    feed4(4'b0110, 4'b0110, -1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = (k == 2) ? ra : 4'($urandom_range(0, 15));
      start4(ra, rb);
      feed4(ra, rb, (k % 3 == 0) ? 1 : -1, 1, 1'b0, 1'b0);
    end

    for (int k = 0; k < 4; k++) begin
      logic [1:0] p;
      p = 2'(k);
      run1(p[1], p[0]);
    end

    for (int k = 0; k < 10; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = (k == 3) ? ra : 8'($urandom_range(0, 255));
      run8(ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
